nibble_serial_addsub_ctrl: RTL

- Multi-cycle controller that reuses one 4-bit ripple-carry adder slice to compute W-bit add/subtract, one nibble per cycle, LSB nibble first.
- Sits between the calculator's operand/opcode front end and its result display/register path.
- Uses val/rdy handshakes on both request and response.
- Trades latency for area: one 4-bit adder instead of a W-bit adder.

---
 rtl/nibble_serial_addsub_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_addsub_ctrl_nibble_add_4b.sv | 24 ++
 rtl/nibble_serial_addsub_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial add/subtract controller.
package nibble_serial_addsub_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble index width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_addsub_ctrl_nibble_add_4b.sv
// Combinational 4-bit ripple-carry adder slice shared across all nibbles.
module nibble_add_4b
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] in0,
    input  logic [NIBBLE_W-1:0] in1,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    always_comb begin
        logic [NIBBLE_W:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            sum[i]   = in0[i] ^ in1[i] ^ c[i];
            c[i + 1] = (in0[i] & in1[i]) | (c[i] & (in0[i] ^ in1[i]));
        end
        cout = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// W-bit add/subtract computed one nibble per cycle through a single 4-bit adder,
// with val/rdy handshakes on request and response.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   req_b,
    input  logic                          req_sub,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    output logic [NIBBLE_W*NIBBLES-1:0]   resp_sum,
    output logic                          resp_cout,
    output logic                          resp_ovf
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = idx_width(NIBBLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
    logic                nib_cout;
    logic                last_nib;

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[NIBBLE_W*i +: NIBBLE_W];
                b_nib = b_q[NIBBLE_W*i +: NIBBLE_W];
            end
        end
    end

    nibble_add_4b u_add (
        .in0  (a_nib),
        .in1  (b_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                // Subtraction as A + ~B + 1: invert B here, inject the 1 as initial carry.
                if (req_val) begin
                    a_d     = req_a;
                    b_d     = req_sub ? ~req_b : req_b;
                    carry_d = req_sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[NIBBLE_W*i +: NIBBLE_W] = nib_sum;
                    end
                end
                carry_d = nib_cout;
                if (last_nib) begin
                    state_d = DONE;
                    cout_d  = nib_cout;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_sum[NIBBLE_W-1] != a_q[W-1]);
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_rdy   = (state_q == IDLE);
    assign resp_val  = (state_q == DONE);
    assign resp_sum  = sum_q;
    assign resp_cout = cout_q;
    assign resp_ovf  = ovf_q;

endmodule
